// File: rtl/dm_scan_reader_pkg.sv
// Shared definitions for the DM scan reader.
// Holds the FSM state encodings, the address/data widths, the per-word address step
// and a helper that word-aligns a byte address.
package dm_scan_reader_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // DM is byte addressed and read one 32-bit word at a time
    localparam logic [ADDR_W-1:0] WORD_STEP = 32'd4;

    // FSM encodings, kept as plain constants so older tools and waveform scripts can decode them
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Drop the byte offset so every access is word aligned
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/dm_out_slot.sv
// Single-entry valid/ready holding register for one read word and its index.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   load                capture in_data/in_index this cycle (only when can_load)
//   in_data, in_index   word and index to capture
//   out_ready           downstream accepts when out_valid && out_ready
//   can_load            slot is empty or is being emptied this cycle
//   out_valid, out_data, out_index   registered output; held stable while stalled
module dm_out_slot
    import dm_scan_reader_pkg::*;
#(
    parameter int IDX_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_index,
    input  logic              out_ready,
    output logic              can_load,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [IDX_W-1:0]  index_q, index_d;

    // A new word may replace the current one only if the current one is gone or leaving now
    assign can_load = !valid_q || out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        data_d  = data_q;
        index_d = index_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            index_d = in_index;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            index_q <= index_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_index = index_q;

endmodule

// File: rtl/dm_scan_reader.sv
// DM scan reader: walks a word-aligned DM region, reads each word combinationally from DM,
// and streams it out on a valid/ready port with its index. Optionally compares each word
// against an incrementing pattern and reports the mismatch count and first failing address.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   start, base_addr, word_count, check_en, check_init   scan request (sampled in IDLE)
//   dm_addr, dm_we, dm_rdata    DM read interface (dm_we is always 0)
//   out_valid, out_ready, out_data, out_index            word stream
//   busy, done                  scan in progress / one-cycle completion pulse
//   err_count, first_err_addr   pattern-check results of the current/last scan
module dm_scan_reader
    import dm_scan_reader_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              check_en,
    input  logic [DATA_W-1:0] check_init,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_index,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    logic [1:0]        state_q,      state_d;
    logic [ADDR_W-1:0] cur_addr_q,   cur_addr_d;
    logic [CNT_W-1:0]  idx_q,        idx_d;
    logic [CNT_W-1:0]  count_q,      count_d;
    logic              check_en_q,   check_en_d;
    logic [DATA_W-1:0] check_init_q, check_init_d;
    logic [CNT_W-1:0]  err_count_q,  err_count_d;
    logic [ADDR_W-1:0] first_err_q,  first_err_d;

    logic capture;
    logic can_load;

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        idx_d        = idx_q;
        count_d      = count_q;
        check_en_d   = check_en_q;
        check_init_d = check_init_q;
        err_count_d  = err_count_q;
        first_err_d  = first_err_q;
        capture      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_d   = word_align(base_addr);
                    count_d      = word_count;
                    check_en_d   = check_en;
                    check_init_d = check_init;
                    err_count_d  = '0;
                    first_err_d  = '0;
                    idx_d        = '0;
                    // An empty scan completes without touching DM
                    state_d      = (word_count == '0) ? ST_DONE : ST_READ;
                end
            end

            ST_READ: begin
                if (can_load) begin
                    capture    = 1'b1;
                    cur_addr_d = cur_addr_q + WORD_STEP;
                    idx_d      = idx_q + CNT_W'(1);
                    if (check_en_q && (dm_rdata != check_init_q + DATA_W'(idx_q))) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                        // err_count never returns to zero within a scan, so zero marks "no mismatch yet"
                        if (err_count_q == '0) begin
                            first_err_d = cur_addr_q;
                        end
                    end
                    if (idx_q == count_q - CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            // Last word is in the output slot; wait for it to be taken
            ST_DRAIN: begin
                if (out_valid && out_ready) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            idx_q        <= '0;
            count_q      <= '0;
            check_en_q   <= 1'b0;
            check_init_q <= '0;
            err_count_q  <= '0;
            first_err_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            check_en_q   <= check_en_d;
            check_init_q <= check_init_d;
            err_count_q  <= err_count_d;
            first_err_q  <= first_err_d;
        end
    end

    dm_out_slot #(
        .IDX_W (CNT_W)
    ) u_out_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (capture),
        .in_data   (dm_rdata),
        .in_index  (idx_q),
        .out_ready (out_ready),
        .can_load  (can_load),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index)
    );

    // DM sees an address only while words are being fetched
    assign dm_addr        = (state_q == ST_READ) ? cur_addr_q : '0;
    assign dm_we          = 1'b0;
    assign busy           = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done           = (state_q == ST_DONE);
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_q;

endmodule
